// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair per cycle (LSB first) to an
// external 1-bit full adder, assembles the sum, and cross-checks it against a parallel add.
module serial_add_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   output logic         fa_a,
   output logic         fa_b,
   output logic         fa_cin,
   input  logic         fa_sum,
   input  logic         fa_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         chk_err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] bit_q, bit_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  sum_q, sum_d;
   logic [W:0]    golden_q, golden_d;
   logic          cin_q, cin_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          chk_q, chk_d;
   logic          last_bit;

   assign last_bit = (bit_q == CW'(W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands shift right each RUN cycle so bit 0 is always the bit under test.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;
      if (state_q == RUN) begin
         fa_a   = a_q[0];
         fa_b   = b_q[0];
         fa_cin = (bit_q == '0) ? cin_q : carry_q;
      end
   end

   always_comb begin
      bit_d    = bit_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      sum_d    = sum_q;
      golden_d = golden_q;
      cin_d    = cin_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      chk_d    = chk_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = in_a;
               b_d      = in_b;
               cin_d    = in_cin;
               golden_d = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
               carry_d  = 1'b0;
               bit_d    = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = (acc_q >> 1) | (W'(fa_sum) << (W - 1));
            carry_d = fa_cout;
            if (last_bit) begin
               bit_d  = '0;
               sum_d  = acc_d;
               cout_d = fa_cout;
               ovf_d  = fa_cin ^ fa_cout;
               chk_d  = ({fa_cout, acc_d} != golden_q);
            end else begin
               bit_d = bit_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   // Result registers are only written on the final RUN edge, so they survive into IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         sum_q    <= '0;
         golden_q <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         chk_q    <= 1'b0;
      end else begin
         bit_q    <= bit_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         sum_q    <= sum_d;
         golden_q <= golden_d;
         cin_q    <= cin_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         chk_q    <= chk_d;
      end
   end

   assign sum     = sum_q;
   assign cout    = cout_q;
   assign ovf     = ovf_q;
   assign chk_err = chk_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W = 8) with a behavioural full adder that can
// be forced to a stuck-at-0 sum.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout, ovf, chk_err;
   bit           fa_stuck = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   serial_add_ctrl #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_sum(fa_sum), .fa_cout(fa_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   assign fa_sum  = fa_stuck ? 1'b0 : (fa_a ^ fa_b ^ fa_cin);
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      bit         stuck;
      logic [7:0] s;
      logic       co;
      logic       ov;
      logic       er;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One full transaction; latency counts the accept cycle as cycle 0.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input bit rnd_ready, output logic [7:0] s, output logic co,
                                output logic ov, output logic er, output int lat);
      int  budget;
      bit  hs;
      budget = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 50) checkOutput("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      s = sum; co = cout; ov = ovf; er = chk_err;
      checkOutput("fa_zero_in_done", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 100) begin
         out_ready = rnd_ready ? 1'($urandom) : 1'b1;
         if (out_ready) hs = 1'b1;
         else checkOutput("hold_sum", {24'b0, sum}, {24'b0, s});
         @(negedge clk);
         budget++;
      end
      out_ready = 1'b0;
      if (!hs) checkOutput("handshake_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] s;
      logic       co, ov, er;
      int         lat;
      logic [8:0] g;
      logic [7:0] ra, rb, es;
      logic       rc, eov;
      bit         seen;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h05, 8'h0A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_results", {22'b0, sum, cout, ovf, chk_err}, 32'd0);
      checkOutput("rst_fa", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         fa_stuck = vecs[i].stuck;
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, ov, er, lat);
         fa_stuck = 1'b0;
         checkOutput($sformatf("vec%0d_latency", i), lat, W + 1);
         checkOutput($sformatf("vec%0d_sum", i), {24'b0, s}, {24'b0, vecs[i].s});
         checkOutput($sformatf("vec%0d_cout", i), {31'b0, co}, {31'b0, vecs[i].co});
         checkOutput($sformatf("vec%0d_ovf", i), {31'b0, ov}, {31'b0, vecs[i].ov});
         checkOutput($sformatf("vec%0d_chk", i), {31'b0, er}, {31'b0, vecs[i].er});
      end

      // Backpressure in DONE while a new request is already waiting.
      in_a = 8'h33; in_b = 8'h44; in_cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_a = 8'hEE; in_b = 8'h11;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("bp_latency", lat, W + 1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("bp_sum", {24'b0, sum}, 32'h77);
         checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("bp_retained_sum", {24'b0, sum}, 32'h77);
      @(negedge clk);
      checkOutput("bp_no_accept", {31'b0, in_ready}, 32'd1);

      // Reset during RUN cycle k = 3 discards the operation.
      in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrst_fa", {29'b0, fa_a, fa_b, fa_cin}, 32'd0);
      checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("midrst_results", {22'b0, sum, cout, ovf, chk_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) seen = 1'b1;
      end
      checkOutput("midrst_quiet", {31'b0, seen}, 32'd0);
      checkOutput("midrst_idle", {31'b0, in_ready}, 32'd1);
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, s, co, ov, er, lat);
      checkOutput("after_rst_sum", {24'b0, s}, 32'h46);
      checkOutput("after_rst_flags", {29'b0, co, ov, er}, 32'd0);

      // Random back-to-back traffic against a plain-arithmetic reference.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         g   = 9'(ra) + 9'(rb) + 9'(rc);
         es  = g[7:0];
         eov = (ra[7] == rb[7]) && (es[7] != ra[7]);
         applyStimulus(ra, rb, rc, 1'b1, s, co, ov, er, lat);
         checkOutput("rnd_latency", lat, W + 1);
         checkOutput("rnd_sum", {24'b0, s}, {24'b0, es});
         checkOutput("rnd_cout", {31'b0, co}, {31'b0, g[8]});
         checkOutput("rnd_ovf", {31'b0, ov}, {31'b0, eov});
         checkOutput("rnd_chk", {31'b0, er}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: W, default 8, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand request valid.
REQ-005 Port: in_ready  output  1  controller can accept operands.
REQ-006 Port: in_a  input  W  operand A.
REQ-007 Port: in_b  input  W  operand B.
REQ-008 Port: in_cin  input  1  carry-in to bit 0.
REQ-009 Port: fa_a  output  1  A bit driven to the external 1-bit full_adder.
REQ-010 Port: fa_b  output  1  B bit driven to the full_adder.
REQ-011 Port: fa_cin  output  1  carry driven to the full_adder.
REQ-012 Port: fa_sum  input  1  sum returned by the full_adder (combinational).
REQ-013 Port: fa_cout  input  1  carry_out returned by the full_adder (combinational).
REQ-014 Port: out_valid  output  1  result valid.
REQ-015 Port: out_ready  input  1  consumer accepts result.
REQ-016 Port: sum  output  W  serial sum result.
REQ-017 Port: cout  output  1  final carry out.
REQ-018 Port: ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-019 Port: chk_err  output  1  serial result differs from internal golden {cout,sum} = in_a+in_b+in_cin.

Function
REQ-020 FSM SHALL have three states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-021 IDLE -> RUN on the edge where in_valid && in_ready; operands, in_cin and golden sum (W+1 bits) SHALL be latched on that edge.
REQ-022 RUN SHALL last exactly W cycles; in RUN cycle k (k = 0..W-1, LSB first) fa_a = a[k], fa_b = b[k], fa_cin = in_cin for k=0, else the carry register.
REQ-023 On each RUN edge, sum[k] <= fa_sum and carry register <= fa_cout; on the k = W-1 edge, the value of fa_cin SHALL be saved for ovf.
REQ-024 RUN -> DONE after the k = W-1 edge; out_valid = 1 in DONE only, first asserted W+1 cycles after the accept edge.
REQ-025 In DONE, cout = final carry register, ovf = saved MSB carry-in XOR cout, chk_err = ({cout,sum} != golden); all held stable until out_ready.
REQ-026 DONE -> IDLE on the edge where out_valid && out_ready; in_ready = 1 the following cycle; back-to-back throughput = one add per W+2 cycles minimum.
REQ-027 fa_a, fa_b, fa_cin SHALL be 0 outside RUN.
REQ-028 in_valid while not IDLE SHALL be ignored; operand inputs may change freely outside the accept edge.
REQ-029 sum, cout, ovf, chk_err SHALL retain the last result in IDLE until the next DONE overwrites them; W = 1 SHALL work (one RUN cycle, ovf = cin XOR cout).

Reset
REQ-030 rst asserted at any time (including mid-RUN or in DONE) SHALL immediately force IDLE, bit counter 0, carry 0, and all outputs 0 except in_ready = 1; any in-flight operation is discarded with no out_valid.

Verification (W = 8)
REQ-031 8'h00 + 8'h00, cin 0 -> out_valid 9 cycles after accept; sum 8'h00, cout 0, ovf 0, chk_err 0.
REQ-032 8'hFF + 8'h01, cin 0 -> sum 8'h00, cout 1, ovf 0, chk_err 0; 8'h7F + 8'h01 -> sum 8'h80, cout 0, ovf 1.
REQ-033 Bench full_adder model with fa_sum stuck at 0; 8'h05 + 8'h0A -> sum 8'h00, chk_err 1.
REQ-034 out_ready held low 5 cycles in DONE with in_valid high -> out_valid, sum stable, in_ready 0, no new accept; out_ready high -> IDLE next cycle.
REQ-035 rst pulsed during RUN cycle k = 3 -> out_valid stays 0, fa_* 0, in_ready 1 after release; next add 8'h12 + 8'h34 -> sum 8'h46.
REQ-036 Back-to-back random operands (1000 adds, out_ready random) with correct full_adder -> every result equals golden, chk_err never 1.
